// File: rtl/histo_pkg.sv
// rtl/histo_pkg.sv - shared widths and scan FSM encoding for the histogram peak finder
package histo_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int N_BINS  = 2 ** ADDR_W;
    localparam int TOTAL_W = DATA_W + ADDR_W;
    localparam int WSUM_W  = DATA_W + 2 * ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/histo_stats_acc.sv
// rtl/histo_stats_acc.sv - peak/first/last/total/weighted-sum accumulator over a bin-tagged count stream
module histo_stats_acc
    import histo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               s_tvalid,
    input  logic [ADDR_W-1:0]  s_tuser,
    input  logic [DATA_W-1:0]  s_tdata,
    output logic [ADDR_W-1:0]  peak_bin,
    output logic [DATA_W-1:0]  peak_count,
    output logic [TOTAL_W-1:0] total,
    output logic [WSUM_W-1:0]  wsum,
    output logic [ADDR_W-1:0]  first_bin,
    output logic [ADDR_W-1:0]  last_bin,
    output logic               seen
);

    logic [ADDR_W-1:0]  peak_bin_q, peak_bin_d;
    logic [DATA_W-1:0]  peak_count_q, peak_count_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [WSUM_W-1:0]  wsum_q, wsum_d;
    logic [ADDR_W-1:0]  first_bin_q, first_bin_d;
    logic [ADDR_W-1:0]  last_bin_q, last_bin_d;
    logic               seen_q, seen_d;

    always_comb begin
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
        total_d      = total_q;
        wsum_d       = wsum_q;
        first_bin_d  = first_bin_q;
        last_bin_d   = last_bin_q;
        seen_d       = seen_q;
        if (clr) begin
            peak_bin_d   = '0;
            peak_count_d = '0;
            total_d      = '0;
            wsum_d       = '0;
            first_bin_d  = '0;
            last_bin_d   = '0;
            seen_d       = 1'b0;
        end else if (s_tvalid) begin
            total_d = total_q + TOTAL_W'(s_tdata);
            wsum_d  = wsum_q + WSUM_W'(s_tuser) * WSUM_W'(s_tdata);
            // strictly greater keeps the lowest bin on a tie, bins arrive in ascending order
            if (s_tdata > peak_count_q) begin
                peak_bin_d   = s_tuser;
                peak_count_d = s_tdata;
            end
            if (s_tdata != '0) begin
                if (!seen_q) begin
                    first_bin_d = s_tuser;
                end
                last_bin_d = s_tuser;
                seen_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_bin_q   <= '0;
            peak_count_q <= '0;
            total_q      <= '0;
            wsum_q       <= '0;
            first_bin_q  <= '0;
            last_bin_q   <= '0;
            seen_q       <= 1'b0;
        end else begin
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
            total_q      <= total_d;
            wsum_q       <= wsum_d;
            first_bin_q  <= first_bin_d;
            last_bin_q   <= last_bin_d;
            seen_q       <= seen_d;
        end
    end

    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
    assign total      = total_q;
    assign wsum       = wsum_q;
    assign first_bin  = first_bin_q;
    assign last_bin   = last_bin_q;
    assign seen       = seen_q;

endmodule

// File: rtl/histo_peak_finder.sv
// rtl/histo_peak_finder.sv - scans the histogram RAM once and publishes a peak/total/mean summary
module histo_peak_finder
    import histo_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       ABORT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       RAM_RD,
    output logic [ADDR_W-1:0]          RAM_ADDR,
    input  logic [DATA_W-1:0]          RAM_DATA,
    output logic [ADDR_W-1:0]          PEAK_BIN,
    output logic [DATA_W-1:0]          PEAK_COUNT,
    output logic [DATA_W+ADDR_W-1:0]   TOTAL,
    output logic [DATA_W+2*ADDR_W-1:0] WSUM,
    output logic [ADDR_W-1:0]          FIRST_BIN,
    output logic [ADDR_W-1:0]          LAST_BIN,
    output logic                       EMPTY
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0]  bin_q [RD_LAT];
    logic [ADDR_W-1:0]  bin_d [RD_LAT];
    logic               start_ok;
    logic               load;

    logic [ADDR_W-1:0]  acc_peak_bin, acc_first_bin, acc_last_bin;
    logic [DATA_W-1:0]  acc_peak_count;
    logic [TOTAL_W-1:0] acc_total;
    logic [WSUM_W-1:0]  acc_wsum;
    logic               acc_seen;

    logic [ADDR_W-1:0]  peak_bin_q, first_bin_q, last_bin_q;
    logic [DATA_W-1:0]  peak_count_q;
    logic [TOTAL_W-1:0] total_q;
    logic [WSUM_W-1:0]  wsum_q;
    logic               empty_q;

    // the DONE cycle still counts as busy, so a START landing on it is dropped
    assign start_ok = START && !ABORT && (state_q == ST_IDLE) && !done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_SCAN;
                    addr_d  = '0;
                end
            end
            ST_SCAN: begin
                if (addr_q == '1) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                load    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (ABORT) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            load    = 1'b0;
        end
    end

    // tag pipe mirrors the RAM latency so each returned word carries its bin
    always_comb begin
        vld_d    = '0;
        bin_d[0] = addr_q;
        vld_d[0] = (state_q == ST_SCAN) && !ABORT;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1] && !ABORT;
            bin_d[i] = bin_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge CLK) begin
        bin_q <= bin_d;
    end

    histo_stats_acc u_acc (
        .clk        (CLK),
        .rst        (RST),
        .clr        (start_ok),
        .s_tvalid   (vld_q[RD_LAT-1]),
        .s_tuser    (bin_q[RD_LAT-1]),
        .s_tdata    (RAM_DATA),
        .peak_bin   (acc_peak_bin),
        .peak_count (acc_peak_count),
        .total      (acc_total),
        .wsum       (acc_wsum),
        .first_bin  (acc_first_bin),
        .last_bin   (acc_last_bin),
        .seen       (acc_seen)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            peak_bin_q   <= '0;
            peak_count_q <= '0;
            total_q      <= '0;
            wsum_q       <= '0;
            first_bin_q  <= '0;
            last_bin_q   <= '0;
            empty_q      <= 1'b1;
        end else if (load) begin
            peak_bin_q   <= acc_peak_bin;
            peak_count_q <= acc_peak_count;
            total_q      <= acc_total;
            wsum_q       <= acc_wsum;
            first_bin_q  <= acc_first_bin;
            last_bin_q   <= acc_last_bin;
            empty_q      <= !acc_seen;
        end
    end

    assign BUSY       = (state_q != ST_IDLE) || done_q;
    assign DONE       = done_q;
    assign RAM_RD     = (state_q == ST_SCAN);
    assign RAM_ADDR   = addr_q;
    assign PEAK_BIN   = peak_bin_q;
    assign PEAK_COUNT = peak_count_q;
    assign TOTAL      = total_q;
    assign WSUM       = wsum_q;
    assign FIRST_BIN  = first_bin_q;
    assign LAST_BIN   = last_bin_q;
    assign EMPTY      = empty_q;

endmodule

// File: tb/tb_histo_peak_finder.sv
// tb/tb_histo_peak_finder.sv - randomized self-checking bench for histo_peak_finder at RD_LAT 1, 2 and 4
module tb_histo_peak_finder;

    localparam int NB = 4096;

    typedef struct {
        logic [11:0] pb;
        logic [31:0] pc;
        logic [63:0] tot;
        logic [63:0] ws;
        logic [11:0] fb;
        logic [11:0] lb;
        logic        emp;
    } res_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ABORT;
    logic        start_w [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        rd_w    [3];
    logic        emp_w   [3];
    logic [11:0] addr_w  [3];
    logic [11:0] pb_w    [3];
    logic [11:0] fb_w    [3];
    logic [11:0] lb_w    [3];
    logic [31:0] data_w  [3];
    logic [31:0] pc_w    [3];
    logic [43:0] tot_w   [3];
    logic [55:0] ws_w    [3];

    logic [31:0] mem [NB];
    logic [31:0] p1  [1];
    logic [31:0] p2  [2];
    logic [31:0] p4  [4];

    int   n_chk = 0;
    int   n_err = 0;
    res_t last;

    always #5 CLK = ~CLK;

    histo_peak_finder #(.RD_LAT(1)) u_l1 (
        .CLK(CLK), .RST(RST), .START(start_w[0]), .ABORT(ABORT), .BUSY(busy_w[0]), .DONE(done_w[0]),
        .RAM_RD(rd_w[0]), .RAM_ADDR(addr_w[0]), .RAM_DATA(data_w[0]), .PEAK_BIN(pb_w[0]),
        .PEAK_COUNT(pc_w[0]), .TOTAL(tot_w[0]), .WSUM(ws_w[0]), .FIRST_BIN(fb_w[0]),
        .LAST_BIN(lb_w[0]), .EMPTY(emp_w[0])
    );
    histo_peak_finder #(.RD_LAT(2)) u_l2 (
        .CLK(CLK), .RST(RST), .START(start_w[1]), .ABORT(ABORT), .BUSY(busy_w[1]), .DONE(done_w[1]),
        .RAM_RD(rd_w[1]), .RAM_ADDR(addr_w[1]), .RAM_DATA(data_w[1]), .PEAK_BIN(pb_w[1]),
        .PEAK_COUNT(pc_w[1]), .TOTAL(tot_w[1]), .WSUM(ws_w[1]), .FIRST_BIN(fb_w[1]),
        .LAST_BIN(lb_w[1]), .EMPTY(emp_w[1])
    );
    histo_peak_finder #(.RD_LAT(4)) u_l4 (
        .CLK(CLK), .RST(RST), .START(start_w[2]), .ABORT(ABORT), .BUSY(busy_w[2]), .DONE(done_w[2]),
        .RAM_RD(rd_w[2]), .RAM_ADDR(addr_w[2]), .RAM_DATA(data_w[2]), .PEAK_BIN(pb_w[2]),
        .PEAK_COUNT(pc_w[2]), .TOTAL(tot_w[2]), .WSUM(ws_w[2]), .FIRST_BIN(fb_w[2]),
        .LAST_BIN(lb_w[2]), .EMPTY(emp_w[2])
    );

    // RAM models: junk is returned for cycles without a read request
    always @(posedge CLK) begin
        p1[0] <= rd_w[0] ? mem[addr_w[0]] : $urandom;
        p2[0] <= rd_w[1] ? mem[addr_w[1]] : $urandom;
        p2[1] <= p2[0];
        p4[0] <= rd_w[2] ? mem[addr_w[2]] : $urandom;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign data_w[0] = p1[0];
    assign data_w[1] = p2[1];
    assign data_w[2] = p4[3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r.pb = '0; r.pc = '0; r.tot = '0; r.ws = '0; r.fb = '0; r.lb = '0; r.emp = 1'b1;
        return r;
    endfunction

    function automatic res_t ref_model();
        res_t        r;
        logic [31:0] mx;
        r  = zero_res();
        mx = '0;
        for (int k = 0; k < NB; k++) begin
            r.tot += 64'(mem[k]);
            r.ws  += 64'(k) * 64'(mem[k]);
            if (mem[k] > mx) mx = mem[k];
        end
        r.pc = mx;
        for (int k = NB - 1; k >= 0; k--) if (mem[k] == mx) r.pb = 12'(k);
        for (int k = NB - 1; k >= 0; k--) if (mem[k] != 0) begin r.fb = 12'(k); r.emp = 1'b0; end
        for (int k = 0; k < NB; k++) if (mem[k] != 0) r.lb = 12'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input int d, input res_t e);
        chk($sformatf("%s_L%0d_peak_bin", tag, lat_of(d)), 64'(pb_w[d]), 64'(e.pb));
        chk($sformatf("%s_L%0d_peak_count", tag, lat_of(d)), 64'(pc_w[d]), 64'(e.pc));
        chk($sformatf("%s_L%0d_total", tag, lat_of(d)), 64'(tot_w[d]), e.tot);
        chk($sformatf("%s_L%0d_wsum", tag, lat_of(d)), 64'(ws_w[d]), e.ws);
        chk($sformatf("%s_L%0d_first", tag, lat_of(d)), 64'(fb_w[d]), 64'(e.fb));
        chk($sformatf("%s_L%0d_last", tag, lat_of(d)), 64'(lb_w[d]), 64'(e.lb));
        chk($sformatf("%s_L%0d_empty", tag, lat_of(d)), 64'(emp_w[d]), 64'(e.emp));
    endtask

    task automatic fill_random();
        for (int k = 0; k < NB; k++) begin
            case ($urandom_range(0, 3))
                0:       mem[k] = $urandom;
                1:       mem[k] = $urandom_range(0, 50);
                default: mem[k] = '0;
            endcase
        end
    endtask

    task automatic run_scan(input string name, input int abort_at, input bit repulse);
        res_t e;
        int   rd_n [3];
        int   done_n [3];
        int   done_at [3];
        int   addr_bad [3];
        int   busy_bad [3];
        int   blast;
        for (int d = 0; d < 3; d++) begin
            rd_n[d] = 0; done_n[d] = 0; done_at[d] = 0; addr_bad[d] = 0; busy_bad[d] = 0;
        end
        e = (abort_at > 0) ? last : ref_model();
        for (int d = 0; d < 3; d++) start_w[d] = 1'b1;
        for (int n = 1; n <= 4200; n++) begin
            @(negedge CLK);
            ABORT = 1'b0;
            for (int d = 0; d < 3; d++) begin
                start_w[d] = 1'b0;
                blast = (abort_at > 0) ? abort_at : NB + lat_of(d) + 2;
                if (busy_w[d] !== (n <= blast)) busy_bad[d]++;
                if (rd_w[d] === 1'b1) begin
                    if (addr_w[d] !== 12'(rd_n[d])) addr_bad[d]++;
                    rd_n[d]++;
                end
                if (done_w[d] === 1'b1) begin
                    done_n[d]++;
                    done_at[d] = n;
                    if (repulse) start_w[d] = 1'b1;
                end
                if (repulse && n == 1000) start_w[d] = 1'b1;
            end
            if (n == abort_at) ABORT = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_L%0d_busy_window", name, lat_of(d)), 64'(busy_bad[d]), 64'd0);
            if (abort_at > 0) begin
                chk($sformatf("%s_L%0d_no_done", name, lat_of(d)), 64'(done_n[d]), 64'd0);
                chk($sformatf("%s_L%0d_reads", name, lat_of(d)), 64'(rd_n[d]), 64'(abort_at));
            end else begin
                chk($sformatf("%s_L%0d_done_count", name, lat_of(d)), 64'(done_n[d]), 64'd1);
                chk($sformatf("%s_L%0d_done_cycle", name, lat_of(d)), 64'(done_at[d]), 64'(NB + lat_of(d) + 2));
                chk($sformatf("%s_L%0d_reads", name, lat_of(d)), 64'(rd_n[d]), 64'(NB));
            end
            chk($sformatf("%s_L%0d_addr_seq", name, lat_of(d)), 64'(addr_bad[d]), 64'd0);
            cmp_res(name, d, e);
        end
        if (abort_at == 0) last = e;
    endtask

    initial begin
        RST   = 1'b1;
        ABORT = 1'b0;
        for (int d = 0; d < 3; d++) start_w[d] = 1'b0;
        for (int k = 0; k < NB; k++) mem[k] = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_L%0d_busy", lat_of(d)), 64'(busy_w[d]), 64'd0);
            chk($sformatf("reset_L%0d_done", lat_of(d)), 64'(done_w[d]), 64'd0);
            chk($sformatf("reset_L%0d_rd", lat_of(d)), 64'(rd_w[d]), 64'd0);
            chk($sformatf("reset_L%0d_addr", lat_of(d)), 64'(addr_w[d]), 64'd0);
            cmp_res("reset", d, zero_res());
        end
        last = zero_res();

        for (int k = 0; k < NB; k++) mem[k] = 32'(k);
        run_scan("ramp", 0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk("ramp_total_const", 64'(tot_w[d]), 64'd8386560);
            chk("ramp_peak_const", 64'(pb_w[d]), 64'd4095);
            chk("ramp_first_const", 64'(fb_w[d]), 64'd1);
        end

        for (int k = 0; k < NB; k++) mem[k] = '0;
        mem[100] = 32'd7;
        run_scan("spike", 0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk("spike_wsum_const", 64'(ws_w[d]), 64'd700);
            chk("spike_last_const", 64'(lb_w[d]), 64'd100);
        end

        mem[100] = '0;
        mem[10]  = 32'd5;
        mem[20]  = 32'd5;
        run_scan("tie", 0, 1'b0);
        for (int d = 0; d < 3; d++) chk("tie_peak_const", 64'(pb_w[d]), 64'd10);

        for (int k = 0; k < NB; k++) mem[k] = '0;
        run_scan("zero", 0, 1'b0);

        for (int k = 0; k < NB; k++) mem[k] = 32'hFFFF_FFFF;
        run_scan("full", 0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk("full_total_const", 64'(tot_w[d]), 64'd4096 * 64'hFFFF_FFFF);
            chk("full_wsum_const", 64'(ws_w[d]), 64'd8386560 * 64'hFFFF_FFFF);
        end

        fill_random();
        run_scan("rand_repulse", 0, 1'b1);

        fill_random();
        run_scan("abort", 2000, 1'b0);
        run_scan("after_abort", 0, 1'b0);

        fill_random();
        for (int d = 0; d < 3; d++) start_w[d] = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 3; d++) start_w[d] = 1'b0;
        repeat (499) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_L%0d_busy", lat_of(d)), 64'(busy_w[d]), 64'd0);
            chk($sformatf("midrst_L%0d_rd", lat_of(d)), 64'(rd_w[d]), 64'd0);
            cmp_res("midrst", d, zero_res());
        end
        last = zero_res();

        fill_random();
        run_scan("rand_final", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
